sc_io_datamem: RTL

SC_IO_DATAMEM -- requirements
Module: sc_io_datamem

---
 rtl/sc_io_datamem.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sc_io_datamem.sv
// ---------------------------------------------------------------------------
// sc_io_datamem
//
// Data memory for a single-cycle CPU with memory-mapped I/O. The low half
// of the address window (addr[7]=0) is word RAM, and the high half
// (addr[7]=1) is a small register file:
//
//   offset 0..NUM_OUT-1     out_reg[i]            read / write
//   offset 8..8+NUM_IN-1    synchronised in_port  read only
//   offset 16               chg_status            read / write-1-to-clear
//   offset 17               irq_mask              read / write
//   offset 24..24+NUM_OUT-1 out_reg[i] toggle     write XORs, read returns
//   anything else           reads 0, writes dropped
//
// Request/acknowledge protocol: req is sampled on every rising edge with no
// backpressure. A request accepted at edge N (req=1, reset=0) produces
// ack=1 for exactly the following cycle. A read returns rdata during that
// ack cycle, and a write returns rdata=0. When reset is high, no request is
// accepted, and an ack that would otherwise show in that cycle is
// suppressed.
//
// Ports
//   clock     single clock, rising edge
//   reset     synchronous, active-high
//   req       access request
//   we        1 = write, 0 = read (qualified by req)
//   addr      byte address; word index addr[31:2]
//   wdata     write data
//   ack       completion strobe for last cycle's request
//   rdata     read data, valid while ack=1
//   in_port   NUM_IN asynchronous input words, port i at [i*DATA_W +: DATA_W]
//   out_port  NUM_OUT registered output words, same packing
//   irq       registered |(chg_status & irq_mask)
// ---------------------------------------------------------------------------
module sc_io_datamem #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64,
    parameter int NUM_IN    = 2,
    parameter int NUM_OUT   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req,
    input  logic                      we,
    input  logic [31:0]               addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic                      ack,
    output logic [DATA_W-1:0]         rdata,
    input  logic [NUM_IN*DATA_W-1:0]  in_port,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic                      irq
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem   [MEM_DEPTH];
    logic [DATA_W-1:0] r_out   [NUM_OUT];
    logic [DATA_W-1:0] r_sync1 [NUM_IN];
    logic [DATA_W-1:0] r_sync2 [NUM_IN];
    logic [DATA_W-1:0] r_prev  [NUM_IN];
    logic [NUM_IN-1:0] r_chg;
    logic [NUM_IN-1:0] r_mask;
    logic              r_irq;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;

    // ------------------------------------------------------------------
    // Request qualification and address decode
    // ------------------------------------------------------------------
    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic              w_io;
    logic [4:0]        w_off;
    logic [AW-1:0]     w_ram_idx;
    logic              w_ram_wr;
    logic              w_io_wr;
    logic              w_unused_addr;

    assign w_acc     = req & ~reset;
    assign w_wr      = w_acc & we;
    assign w_rd      = w_acc & ~we;
    assign w_io      = addr[7];
    assign w_off     = addr[6:2];
    // Upper address bits fall away here, so RAM accesses wrap around.
    assign w_ram_idx = addr[AW+1:2];
    assign w_ram_wr  = w_wr & ~w_io;
    assign w_io_wr   = w_wr & w_io;

    // Byte offset and bits above the I/O window take no part in decode.
    assign w_unused_addr = ^{addr[31:8], addr[1:0]};

    // Per-register write strobes
    logic [NUM_OUT-1:0] w_out_wr;
    logic [NUM_OUT-1:0] w_tgl_wr;
    logic               w_chg_w1c;
    logic               w_mask_wr;

    always_comb begin
        w_out_wr  = '0;
        w_tgl_wr  = '0;
        w_chg_w1c = w_io_wr && (w_off == 5'd16);
        w_mask_wr = w_io_wr && (w_off == 5'd17);
        for (int i = 0; i < NUM_OUT; i++) begin
            w_out_wr[i] = w_io_wr && (w_off == 5'(i));
            w_tgl_wr[i] = w_io_wr && (w_off == 5'(24 + i));
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational from the current state; registered below)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_io_rd;
    logic [DATA_W-1:0] w_rd_val;

    always_comb begin
        w_io_rd = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            // Plain and toggle aliases both read back the output register.
            if ((w_off == 5'(i)) || (w_off == 5'(24 + i)))
                w_io_rd = r_out[i];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_off == 5'(8 + i))
                w_io_rd = r_sync2[i];
        end
        if (w_off == 5'd16) begin
            w_io_rd             = '0;
            w_io_rd[NUM_IN-1:0] = r_chg;
        end
        if (w_off == 5'd17) begin
            w_io_rd             = '0;
            w_io_rd[NUM_IN-1:0] = r_mask;
        end
    end

    assign w_rd_val = w_io ? w_io_rd : r_mem[w_ram_idx];

    // ------------------------------------------------------------------
    // Change detection
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] w_chg_set;
    logic [NUM_IN-1:0] w_chg_clr;

    always_comb begin
        w_chg_set = '0;
        for (int i = 0; i < NUM_IN; i++)
            w_chg_set[i] = (r_sync2[i] != r_prev[i]);
        w_chg_clr = w_chg_w1c ? wdata[NUM_IN-1:0] : '0;
    end

    // ------------------------------------------------------------------
    // RAM: never reset; writes land at the end of the request cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_ram_wr)
            r_mem[w_ram_idx] <= wdata;
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= req;
            r_rdata <= w_rd ? w_rd_val : '0;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++)
                r_out[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_out_wr[i])
                    r_out[i] <= wdata;
                else if (w_tgl_wr[i])
                    r_out[i] <= r_out[i] ^ wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser, previous sample, status, mask, irq
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_sync1[i] <= '0;
                r_sync2[i] <= '0;
                r_prev[i]  <= '0;
            end
            r_chg  <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_sync1[i] <= in_port[i*DATA_W +: DATA_W];
                r_sync2[i] <= r_sync1[i];
                r_prev[i]  <= r_sync2[i];
            end
            // A fresh change beats a simultaneous clear of the same bit.
            r_chg <= (r_chg & ~w_chg_clr) | w_chg_set;
            if (w_mask_wr)
                r_mask <= wdata[NUM_IN-1:0];
            r_irq <= |(r_chg & r_mask);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The response flops still hold last cycle's result during the first
    // reset cycle, so they are masked with reset here.
    assign ack   = r_ack & ~reset;
    assign rdata = reset ? '0 : r_rdata;
    assign irq   = r_irq;

    always_comb begin
        out_port = '0;
        for (int i = 0; i < NUM_OUT; i++)
            out_port[i*DATA_W +: DATA_W] = r_out[i];
    end

endmodule
